// File: rtl/serial_rx.sv
// Oversampling asynchronous serial receiver: 8N1 frames, LSB first, with
// start-bit validation, framing-error reporting and back-to-back frame support.
module serial_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inbit,
  output logic [7:0] databyte,
  output logic       valid,
  output logic       framing_err,
  output logic       receiving,
  output logic [3:0] count
);

  localparam int unsigned CntW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q;
  logic            sync1_q;
  logic            sync2_q;
  logic            prev_q;
  logic [2:0]      arm_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      count_q;
  logic [7:0]      shift_q;
  logic [7:0]      databyte_q;
  logic            valid_q;
  logic            ferr_q;

  logic s_in;
  logic fall;

  assign s_in = sync2_q;

  // Reset presets the synchronizer to idle-high, so edges are ignored until
  // prev_q holds a real line sample; a line stuck low never starts a frame.
  assign fall = arm_q[2] & prev_q & ~s_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      arm_q      <= 3'b000;
      cnt_q      <= '0;
      count_q    <= 4'd0;
      shift_q    <= 8'd0;
      databyte_q <= 8'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q <= inbit;
      sync2_q <= sync1_q;
      prev_q  <= s_in;
      arm_q   <= {arm_q[1:0], 1'b1};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (fall) begin
            state_q <= StStart;
            cnt_q   <= '0;
            count_q <= 4'd0;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q   <= '0;
            state_q <= s_in ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q                 <= '0;
            shift_q[count_q[2:0]] <= s_in;
            count_q               <= count_q + 4'd1;
            if (count_q == 4'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (s_in) begin
              databyte_q <= shift_q;
              valid_q    <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign databyte    = databyte_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign receiving   = (state_q != StIdle);
  assign count       = count_q;

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed frame table, hand-written corner
// sequences and random frames checked against a frame-level event model.
module tb_serial_rx;

  localparam int unsigned Os = 16;
  // Inbit first seen low at cycle f -> START at f+2 -> stop sampled Os/2+9*Os later.
  localparam int Lat = 2 + Os / 2 + 9 * Os;

  logic       clk;
  logic       reset;
  logic       inbit;
  logic [7:0] databyte;
  logic       valid;
  logic       framing_err;
  logic       receiving;
  logic [3:0] count;

  serial_rx #(
    .OVERSAMPLE(Os)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inbit      (inbit),
    .databyte   (databyte),
    .valid      (valid),
    .framing_err(framing_err),
    .receiving  (receiving),
    .count      (count)
  );

  typedef struct {
    int         cyc;
    bit         ferr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    bit         exp_v;
    bit         exp_f;
    logic [7:0] exp_b;
  } vec_t;

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic       rst_at_edge = 1'b0;
  bit         sb_en = 1'b0;
  ev_t        exp_q[$];
  logic [7:0] sb_byte = 8'd0;
  int         pulse_cnt = 0;
  int         last_cyc = -1;
  logic       last_v = 1'b0;
  logic       last_f = 1'b0;
  bit         rx_seen = 1'b0;

  ev_t        mon_ev;
  logic       sb_v;
  logic       sb_f;

  vec_t       vecs[7];
  int         row_pc[7];
  int         pc0;
  int         pcyc;
  logic [7:0] mdl_byte;
  logic [7:0] rd;
  bit         rs;
  int         rg;
  logic [7:0] abort_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  // Monitor: pulse bookkeeping plus a per-cycle scoreboard against the event queue.
  always begin
    @(negedge clk);
    if (valid === 1'b1 || framing_err === 1'b1) begin
      pulse_cnt++;
      last_cyc = cyc;
      last_v   = valid;
      last_f   = framing_err;
    end
    if (receiving === 1'b1) rx_seen = 1'b1;
    if (sb_en) begin
      sb_v = 1'b0;
      sb_f = 1'b0;
      if (rst_at_edge) begin
        exp_q.delete();
        sb_byte = 8'd0;
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.ferr) sb_f = 1'b1;
        else begin
          sb_v    = 1'b1;
          sb_byte = mon_ev.data;
        end
      end
      chk($sformatf("scoreboard@%0d", cyc), {22'd0, valid, framing_err, databyte},
          {22'd0, sb_v, sb_f, sb_byte});
    end
  end

  task automatic drive_level(input logic lvl, input int n);
    inbit = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input logic lvl);
    reset = 1'b1;
    inbit = lvl;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_and_check(input string nm, input logic [7:0] d, input bit stop,
                                input int gap, input logic tail, input bit exp_v,
                                input bit exp_f, input logic [7:0] exp_b, output int pc);
    ev_t e;
    int  f;
    int  p0;
    p0     = pulse_cnt;
    f      = cyc + 1;
    e.cyc  = f + Lat;
    e.ferr = !stop;
    e.data = d;
    exp_q.push_back(e);
    drive_level(1'b0, Os);
    for (int i = 0; i < 8; i++) drive_level(d[i], Os);
    drive_level(stop, Os);
    drive_level(tail, gap);
    chk({nm, "/pulses"}, pulse_cnt - p0, 1);
    chk({nm, "/when"}, last_cyc, f + Lat);
    chk({nm, "/valid"}, {31'd0, last_v}, {31'd0, exp_v});
    chk({nm, "/ferr"}, {31'd0, last_f}, {31'd0, exp_f});
    chk({nm, "/databyte"}, {24'd0, databyte}, {24'd0, exp_b});
    chk({nm, "/count"}, {28'd0, count}, 32'd8);
    pc = last_cyc;
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 20, exp_v: 1'b1, exp_f: 1'b0, exp_b: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, gap: 0,  exp_v: 1'b1, exp_f: 1'b0, exp_b: 8'h3C};
    vecs[2] = '{data: 8'hC3, stop: 1'b1, gap: 20, exp_v: 1'b1, exp_f: 1'b0, exp_b: 8'hC3};
    vecs[3] = '{data: 8'h5A, stop: 1'b0, gap: 20, exp_v: 1'b0, exp_f: 1'b1, exp_b: 8'hC3};
    vecs[4] = '{data: 8'h00, stop: 1'b1, gap: 5,  exp_v: 1'b1, exp_f: 1'b0, exp_b: 8'h00};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, gap: 5,  exp_v: 1'b1, exp_f: 1'b0, exp_b: 8'hFF};
    vecs[6] = '{data: 8'h81, stop: 1'b0, gap: 3,  exp_v: 1'b0, exp_f: 1'b1, exp_b: 8'hFF};

    reset = 1'b1;
    inbit = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb_en = 1'b1;
    drive_level(1'b1, 20);
    chk("reset/databyte", {24'd0, databyte}, 32'd0);
    chk("reset/valid", {31'd0, valid}, 32'd0);
    chk("reset/ferr", {31'd0, framing_err}, 32'd0);
    chk("reset/receiving", {31'd0, receiving}, 32'd0);
    chk("reset/count", {28'd0, count}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      send_and_check($sformatf("row%0d", i), vecs[i].data, vecs[i].stop, vecs[i].gap, 1'b1,
                     vecs[i].exp_v, vecs[i].exp_f, vecs[i].exp_b, row_pc[i]);
    end
    chk("b2b/spacing", row_pc[2] - row_pc[1], 160);
    mdl_byte = 8'hFF;

    // 4-cycle glitch: START is entered, then rejected at mid start bit.
    pc0 = pulse_cnt;
    drive_level(1'b0, 4);
    drive_level(1'b1, 2);
    chk("glitch/receiving_hi", {31'd0, receiving}, 32'd1);
    drive_level(1'b1, 20);
    chk("glitch/receiving_lo", {31'd0, receiving}, 32'd0);
    chk("glitch/pulses", pulse_cnt - pc0, 0);
    chk("glitch/databyte", {24'd0, databyte}, {24'd0, mdl_byte});
    chk("glitch/count", {28'd0, count}, 32'd0);

    // Bad stop bit, line then stays low: no restart, count keeps 8.
    send_and_check("ferr_low", 8'h5A, 1'b0, 40, 1'b0, 1'b0, 1'b1, mdl_byte, pcyc);
    chk("ferr_low/receiving", {31'd0, receiving}, 32'd0);
    drive_level(1'b1, 20);
    send_and_check("after_ferr", 8'h66, 1'b1, 20, 1'b1, 1'b1, 1'b0, 8'h66, pcyc);
    mdl_byte = 8'h66;

    // Reset in the middle of data bit 4.
    abort_b = 8'hEE;
    pc0 = pulse_cnt;
    drive_level(1'b0, Os);
    for (int i = 0; i < 4; i++) drive_level(abort_b[i], Os);
    drive_level(abort_b[4], Os / 2);
    apply_reset(1'b1);
    chk("abort/receiving", {31'd0, receiving}, 32'd0);
    chk("abort/databyte", {24'd0, databyte}, 32'd0);
    chk("abort/count", {28'd0, count}, 32'd0);
    drive_level(1'b1, 200);
    chk("abort/pulses", pulse_cnt - pc0, 0);
    send_and_check("after_abort", 8'h81, 1'b1, 20, 1'b1, 1'b1, 1'b0, 8'h81, pcyc);

    // Line held low straight out of reset.
    apply_reset(1'b0);
    rx_seen = 1'b0;
    pc0 = pulse_cnt;
    drive_level(1'b0, 400);
    chk("stuck/rx_seen", {31'd0, rx_seen}, 32'd0);
    chk("stuck/pulses", pulse_cnt - pc0, 0);
    chk("stuck/valid", {31'd0, valid}, 32'd0);
    chk("stuck/count", {28'd0, count}, 32'd0);
    drive_level(1'b1, 20);
    mdl_byte = 8'h00;

    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      rg = rs ? int'($urandom_range(0, 24)) : int'($urandom_range(1, 24));
      if (rs) mdl_byte = rd;
      send_and_check($sformatf("rand%0d", i), rd, rs, rg, 1'b1, rs, !rs, mdl_byte, pcyc);
    end

    drive_level(1'b1, 10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
